// File: rtl/mem2_stage_pkg.sv
// Shared widths, bus layouts and LSU encodings for the MEM2 pipeline stage.
// Includes the alignment rule used by both the stage and its consumers.
package mem2_stage_pkg;

  localparam int unsigned STALL_WD     = 8;
  localparam int unsigned LSU_WD       = 8;
  localparam int unsigned MEM12MEM2_WD = 149;
  localparam int unsigned MEM22WB_WD   = 102;
  localparam int unsigned BYPASS_WD    = 38;

  localparam int unsigned STALL_OWN  = 5;
  localparam int unsigned STALL_DOWN = 6;

  // lsu_op one-hot bit positions, MSB first: {lb, lbu, lh, lhu, lw, sb, sh, sw}
  localparam int unsigned LSU_LB  = 7;
  localparam int unsigned LSU_LBU = 6;
  localparam int unsigned LSU_LH  = 5;
  localparam int unsigned LSU_LHU = 4;
  localparam int unsigned LSU_LW  = 3;
  localparam int unsigned LSU_SB  = 2;
  localparam int unsigned LSU_SH  = 1;
  localparam int unsigned LSU_SW  = 0;

  // sel_rf_res[0] picks load data; bits [2:1] are reserved
  localparam int unsigned SEL_RF_LOAD = 0;

  typedef struct packed {
    logic [LSU_WD-1:0] lsu_op;
    logic [3:0]        data_ram_sel;
    logic [2:0]        sel_rf_res;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       ex_result;
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic [31:0]       sram_rdata;
  } mem12mem2_t;

  function automatic logic misaligned(input logic [LSU_WD-1:0] lsu_op,
                                      input logic [1:0]        offset);
    logic half_acc;
    logic word_acc;
    half_acc = lsu_op[LSU_LH] | lsu_op[LSU_LHU] | lsu_op[LSU_SH];
    word_acc = lsu_op[LSU_LW] | lsu_op[LSU_SW];
    return (half_acc & offset[0]) | (word_acc & (|offset));
  endfunction

endpackage

// File: rtl/mem2_stage_load_align.sv
// Extracts and extends load data from a 32-bit SRAM word by access type and offset.
// Non-load ops pass the raw word through; the stage only uses it for loads.
module load_align
  import mem2_stage_pkg::*;
(
  input  logic [LSU_WD-1:0] i_lsu_op,
  input  logic [1:0]        i_offset,
  input  logic [31:0]       i_rdata,
  output logic [31:0]       o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused_store;

  assign w_byte = 8'(i_rdata >> {i_offset, 3'b000});
  assign w_half = 16'(i_rdata >> {i_offset[1], 4'b0000});

  assign w_unused_store = ^{i_lsu_op[LSU_SB], i_lsu_op[LSU_SH], i_lsu_op[LSU_SW]};

  always_comb begin
    o_data = i_rdata;
    if (i_lsu_op[LSU_LB]) begin
      o_data = {{24{w_byte[7]}}, w_byte};
    end else if (i_lsu_op[LSU_LBU]) begin
      o_data = {24'h000000, w_byte};
    end else if (i_lsu_op[LSU_LH]) begin
      o_data = {{16{w_half[15]}}, w_half};
    end else if (i_lsu_op[LSU_LHU]) begin
      o_data = {16'h0000, w_half};
    end
  end

endmodule

// File: rtl/mem2_stage.sv
// MEM2 pipeline stage: registers the MEM1 bus, aligns load data, flags misaligned
// accesses, drives writeback/bypass buses and counts retiring instructions.
module mem2_stage
  import mem2_stage_pkg::*;
#(
  parameter int unsigned CNT_WD = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [MEM12MEM2_WD-1:0] mem12mem2_bus,
  output logic [MEM22WB_WD-1:0]   mem22wb_bus,
  output logic [BYPASS_WD-1:0]    mem22rf_bus,
  output logic                    misalign_err,
  output logic [CNT_WD-1:0]       retire_cnt
);

  mem12mem2_t        r_stage;
  mem12mem2_t        w_in;
  logic [CNT_WD-1:0] r_retire_cnt;
  logic              w_stall_own;
  logic              w_stall_down;
  logic              w_valid;
  logic              w_misalign;
  logic              w_rf_we;
  logic [31:0]       w_load_data;
  logic [31:0]       w_rf_wdata;
  logic              w_unused_bits;

  assign w_in         = mem12mem2_t'(mem12mem2_bus);
  assign w_stall_own  = stall[STALL_OWN];
  assign w_stall_down = stall[STALL_DOWN];

  // Bubble takes priority over hold when this stage stalls but downstream moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
    end else if (w_stall_own && !w_stall_down) begin
      r_stage <= '0;
    end else if (!w_stall_own) begin
      r_stage <= w_in;
    end
  end

  assign w_valid = |r_stage.inst;

  // A held instruction is counted only on the edge where it leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (w_valid && !w_stall_down) begin
      r_retire_cnt <= r_retire_cnt + CNT_WD'(1);
    end
  end

  load_align u_load_align (
    .i_lsu_op (r_stage.lsu_op),
    .i_offset (r_stage.ex_result[1:0]),
    .i_rdata  (r_stage.sram_rdata),
    .o_data   (w_load_data)
  );

  assign w_misalign = misaligned(r_stage.lsu_op, r_stage.ex_result[1:0]);
  assign w_rf_wdata = r_stage.sel_rf_res[SEL_RF_LOAD] ? w_load_data : r_stage.ex_result;
  assign w_rf_we    = r_stage.rf_we & (|r_stage.rf_waddr) & ~w_misalign;

  assign mem22wb_bus  = {w_rf_we, r_stage.rf_waddr, w_rf_wdata, r_stage.pc, r_stage.inst};
  assign mem22rf_bus  = {w_rf_we, r_stage.rf_waddr, w_rf_wdata};
  assign misalign_err = w_misalign;
  assign retire_cnt   = r_retire_cnt;

  assign w_unused_bits = ^{r_stage.data_ram_sel, r_stage.sel_rf_res[2:1],
                           stall[STALL_WD-1:STALL_DOWN+1], stall[STALL_OWN-1:0]};

endmodule

// File: tb/tb_mem2_stage.sv
// Self-checking bench for mem2_stage: table vectors through a scoreboard queue,
// plus sequences for bubble, held stall, counter wrap and reset during stall.
module tb_mem2_stage;
  import mem2_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [STALL_WD-1:0]     stall;
  logic [MEM12MEM2_WD-1:0] bus;
  logic [MEM22WB_WD-1:0]   wb, wb4;
  logic [BYPASS_WD-1:0]    rf, rf4;
  logic                    mis, mis4;
  logic [63:0]             cnt;
  logic [3:0]              cnt4;

  always #5 clk = ~clk;

  mem2_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .mem12mem2_bus(bus),
    .mem22wb_bus(wb), .mem22rf_bus(rf), .misalign_err(mis), .retire_cnt(cnt)
  );

  mem2_stage #(.CNT_WD(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .mem12mem2_bus(bus),
    .mem22wb_bus(wb4), .mem22rf_bus(rf4), .misalign_err(mis4), .retire_cnt(cnt4)
  );

  typedef struct {
    logic [7:0]  lsu;
    logic [2:0]  sel;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] ex;
    logic [31:0] sram;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] e_wdata;
    logic        e_we;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic [MEM22WB_WD-1:0] wb;
    logic [BYPASS_WD-1:0]  rf;
    logic                  mis;
  } exp_t;

  exp_t        sbq[$];
  exp_t        last_e;
  vec_t        tbl[16];
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic        m_valid = 1'b0;
  logic [63:0] m_cnt   = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] lsu, input logic [2:0] sel, input logic we,
                              input logic [4:0] wa, input logic [31:0] ex, input logic [31:0] sram,
                              input logic [31:0] e_wdata, input logic e_we, input logic e_mis);
    vec_t v;
    v.lsu = lsu; v.sel = sel; v.we = we; v.wa = wa; v.ex = ex; v.sram = sram;
    v.inst = 32'h0000_0003; v.pc = 32'hBFC0_0000;
    v.e_wdata = e_wdata; v.e_we = e_we; v.e_mis = e_mis;
    return v;
  endfunction

  function automatic vec_t mk_add(input int unsigned i);
    vec_t v;
    v = mk(8'h00, 3'b000, 1'b1, 5'(i + 1), 32'h100 * (i + 1), $urandom,
           32'h100 * (i + 1), 1'b1, 1'b0);
    v.inst = 32'h0000_0020 + i;
    v.pc   = 32'h0000_0400 + 4 * i;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    bus = {v.lsu, 4'hA, v.sel, v.we, v.wa, v.ex, v.pc, v.inst, v.sram};
    e.wb  = {v.e_we, v.wa, v.e_wdata, v.pc, v.inst};
    e.rf  = {v.e_we, v.wa, v.e_wdata};
    e.mis = v.e_mis;
    sbq.push_back(e);
  endtask

  // Advances one clock while tracking stage occupancy and expected retirements.
  task automatic tick();
    logic nv;
    nv = m_valid;
    if (rst) begin
      m_cnt = '0;
      nv    = 1'b0;
    end else begin
      if (m_valid && !stall[6]) m_cnt++;
      if (stall[5] && !stall[6]) nv = 1'b0;
      else if (!stall[5]) nv = (bus[63:32] != 32'h0);
    end
    @(posedge clk);
    #1;
    m_valid = nv;
  endtask

  task automatic cmp_exp(input string name, input exp_t e);
    chk({name, "_wb"}, 128'(wb), 128'(e.wb));
    chk({name, "_rf"}, 128'(rf), 128'(e.rf));
    chk({name, "_mis"}, 128'(mis), 128'(e.mis));
    chk({name, "_wb4"}, 128'(wb4), 128'(e.wb));
    chk({name, "_cnt"}, 128'(cnt), 128'(m_cnt));
    chk({name, "_cnt4"}, 128'(cnt4), 128'(m_cnt[3:0]));
  endtask

  task automatic check_out(input string name);
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got empty scoreboard expected an entry", name);
    end else begin
      last_e = sbq.pop_front();
      cmp_exp(name, last_e);
    end
  endtask

  task automatic check_zero(input string name);
    exp_t z;
    z.wb = '0; z.rf = '0; z.mis = 1'b0;
    cmp_exp(name, z);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus = '0; stall = '0;
    tick();
    rst = 1'b0;
    sbq.delete();
  endtask

  initial begin
    tbl[0]  = mk(8'h80, 3'b001, 1'b1, 5'd3,  32'h1003, 32'h80FF_0000, 32'hFFFF_FF80, 1'b1, 1'b0);
    tbl[1]  = mk(8'h10, 3'b001, 1'b1, 5'd4,  32'h1002, 32'hBEEF_1234, 32'h0000_BEEF, 1'b1, 1'b0);
    tbl[2]  = mk(8'h20, 3'b001, 1'b1, 5'd5,  32'h1002, 32'hBEEF_1234, 32'hFFFF_BEEF, 1'b1, 1'b0);
    tbl[3]  = mk(8'h08, 3'b001, 1'b1, 5'd6,  32'h1001, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    tbl[4]  = mk(8'h00, 3'b000, 1'b1, 5'd7,  32'hDEAD_BEEF, 32'h5555_5555, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tbl[5]  = mk(8'h00, 3'b000, 1'b1, 5'd0,  32'h0000_0042, 32'h0, 32'h0000_0042, 1'b0, 1'b0);
    tbl[6]  = mk(8'h40, 3'b001, 1'b1, 5'd8,  32'h2001, 32'h0000_9A00, 32'h0000_009A, 1'b1, 1'b0);
    tbl[7]  = mk(8'h80, 3'b001, 1'b1, 5'd9,  32'h2000, 32'h0000_007F, 32'h0000_007F, 1'b1, 1'b0);
    tbl[8]  = mk(8'h20, 3'b001, 1'b1, 5'd10, 32'h1000, 32'h0000_8001, 32'hFFFF_8001, 1'b1, 1'b0);
    tbl[9]  = mk(8'h20, 3'b001, 1'b1, 5'd11, 32'h1001, 32'hAABB_CCDD, 32'hFFFF_CCDD, 1'b0, 1'b1);
    tbl[10] = mk(8'h01, 3'b000, 1'b0, 5'd0,  32'h1002, 32'h0, 32'h0000_1002, 1'b0, 1'b1);
    tbl[11] = mk(8'h02, 3'b000, 1'b0, 5'd0,  32'h1002, 32'h0, 32'h0000_1002, 1'b0, 1'b0);
    tbl[12] = mk(8'h08, 3'b001, 1'b1, 5'd12, 32'h1004, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1'b0);
    tbl[13] = mk(8'h00, 3'b110, 1'b1, 5'd13, 32'h0000_0777, 32'hFFFF_FFFF, 32'h0000_0777, 1'b1, 1'b0);
    tbl[14] = mk(8'h04, 3'b000, 1'b0, 5'd0,  32'h1003, 32'h0, 32'h0000_1003, 1'b0, 1'b0);
    tbl[15] = mk(8'h10, 3'b001, 1'b1, 5'd14, 32'h1003, 32'hBEEF_1234, 32'h0000_BEEF, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 16; i++) begin
      tbl[i].inst = 32'h1000_0000 + i;
      tbl[i].pc   = 32'h0000_2000 + 4 * i;
    end

    // Reset with a live instruction on the input bus: outputs must still be zero.
    rst = 1'b1; stall = '0;
    bus = {tbl[4].lsu, 4'hA, tbl[4].sel, tbl[4].we, tbl[4].wa, tbl[4].ex,
           tbl[4].pc, tbl[4].inst, tbl[4].sram};
    tick();
    rst = 1'b0;
    check_zero("reset");

    for (int unsigned i = 0; i < 16; i++) begin
      drive(tbl[i]);
      tick();
      check_out($sformatf("vec%0d", i));
    end
    bus = '0;
    tick();
    chk("table_cnt", 128'(cnt), 128'(64'd16));

    // Bubble: own stall with downstream free clears the stage.
    do_reset();
    drive(mk_add(20));
    tick();
    check_out("bub_add");
    stall = 8'h20;
    tick();
    check_zero("bubble");
    chk("bubble_cnt", 128'(cnt), 128'(64'd1));
    stall = '0; bus = '0;
    tick();
    chk("bubble_cnt_hold", 128'(cnt), 128'(64'd1));

    // Ten instructions with a three-cycle downstream stall after the fifth.
    do_reset();
    for (int unsigned i = 0; i < 10; i++) begin
      drive(mk_add(i));
      tick();
      check_out("stream");
      if (i == 4) begin
        stall = 8'h60;
        for (int unsigned k = 0; k < 3; k++) begin
          tick();
          cmp_exp("stall_hold", last_e);
        end
        stall = '0;
      end
    end
    bus = '0;
    tick();
    chk("stream_cnt10", 128'(cnt), 128'(64'd10));

    // Four-bit counter wraps after sixteen retirements.
    do_reset();
    for (int unsigned i = 0; i < 15; i++) begin
      drive(mk_add(i));
      tick();
      check_out("wrap_fill");
    end
    bus = '0;
    tick();
    chk("cnt4_full", 128'(cnt4), 128'(4'hF));
    drive(mk_add(15));
    tick();
    check_out("wrap_last");
    bus = '0;
    tick();
    chk("cnt4_wrap", 128'(cnt4), 128'(4'h0));
    chk("cnt64_16", 128'(cnt), 128'(64'd16));

    // Reset while an instruction is held discards it uncounted.
    do_reset();
    drive(mk_add(3));
    tick();
    check_out("rst_stall_add");
    stall = 8'h60;
    tick();
    cmp_exp("rst_stall_hold", last_e);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("rst_in_stall");
    chk("rst_in_stall_cnt", 128'(cnt), 128'(64'd0));
    stall = '0; bus = '0;
    tick();
    check_zero("rst_after");
    chk("rst_after_cnt", 128'(cnt), 128'(64'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem2_stage.md
MEM2_STAGE -- requirements
Module: mem2

Interface
REQ-001 Parameter CNT_WD, default 64: width of the retired-instruction counter.
REQ-002 clk  input  1: single clock; all state updates on the rising edge.
REQ-003 rst  input  1: reset, synchronous and active-high.
REQ-004 stall  input  `StallBus: pipeline stall vector; this stage uses stall[5] (own) and stall[6] (downstream).
REQ-005 mem12mem2_bus  input  `MEM12MEM2_WD: upstream bus, MSB to LSB {lsu_op, data_ram_sel[3:0], sel_rf_res[2:0], rf_we, rf_waddr[4:0], ex_result[31:0], pc[31:0], inst[31:0], sram_rdata[31:0]}.
REQ-006 mem22wb_bus  output  `MEM22WB_WD: to writeback, {rf_we, rf_waddr[4:0], rf_wdata[31:0], pc[31:0], inst[31:0]}.
REQ-007 mem22rf_bus  output  `BYPASS_WD: forwarding bus {rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
REQ-008 misalign_err  output  1: registered-stage load/store address misaligned for its access size.
REQ-009 retire_cnt  output  CNT_WD: count of valid instructions leaving this stage.

Function
REQ-010 Stage register: cleared on rst; cleared (bubble) when stall[5]=1 and stall[6]=0; loaded from mem12mem2_bus when stall[5]=0; held otherwise.
REQ-011 lsu_op is 8-bit one-hot {lb, lbu, lh, lhu, lw, sb, sh, sw}, MSB first; all-zero means non-memory instruction.
REQ-012 Stage valid when registered inst != 0; a bubble is all-zero and drives rf_we=0.
REQ-013 Byte offset = ex_result[1:0]; lb/lbu select byte offset*8, lh/lhu select halfword ex_result[1]*16, lw selects full word.
REQ-014 lb/lh sign-extend to 32 bits; lbu/lhu zero-extend.
REQ-015 rf_wdata = extracted load data when sel_rf_res[0]=1, else ex_result; sel_rf_res[2:1] reserved, ignored.
REQ-016 mem22wb_bus and mem22rf_bus are combinational from the stage register; latency mem12mem2_bus -> outputs is one cycle.
REQ-017 rf_we forced to 0 on both output buses when rf_waddr=0 or when misalign_err=1.
REQ-018 misalign_err=1 when (lh|lhu|sh) and ex_result[0]=1, or (lw|sw) and ex_result[1:0]!=0; otherwise 0.
REQ-019 retire_cnt increments by 1 on a rising edge when stage valid and stall[6]=0; holds otherwise.
REQ-020 retire_cnt wraps from all-ones to 0 without flag.
REQ-021 Stall and bubble on the same edge: bubble (REQ-010 priority) wins; a held instruction is counted only once, on the edge it leaves.

Reset
REQ-022 rst clears stage register, retire_cnt to 0; all outputs 0 in the cycle after rst, including misalign_err.
REQ-023 rst asserted mid-stall discards the held instruction; it is not counted.

Structure
REQ-024 `MEM22WB_WD, `LSU_WD (=8), lsu_op bit positions and sel_rf_res encoding belong in define.vh.
REQ-025 One sub-module, load_align: combinational {lsu_op, offset, sram_rdata} -> 32-bit load data.

Verification
REQ-026 lb, ex_result=0x1003, sram_rdata=0x80FF_0000 -> next cycle rf_wdata=0xFFFF_FF80, rf_we=1.
REQ-027 lhu, ex_result=0x1002, sram_rdata=0xBEEF_1234 -> rf_wdata=0x0000_BEEF; lh same -> 0xFFFF_BEEF.
REQ-028 lw, ex_result=0x1001 -> misalign_err=1, rf_we=0 on both buses.
REQ-029 stall[5]=1,stall[6]=0 for 1 cycle after valid add -> bubble, rf_we=0, retire_cnt unchanged.
REQ-030 10 valid instructions with stall[6]=1 for 3 cycles mid-stream -> retire_cnt=10, held instruction output stable during stall.
REQ-031 retire_cnt preset via 2^CNT_WD-1 retirements (CNT_WD=4 build) -> wraps to 0; rst mid-stall -> outputs 0, count 0.
